// File: rtl/dequeue_agent_v0_1.sv
// dequeue_agent_v0_1
// Egress scheduler: picks a port round-robin among those with both a PIFO
// entry and buffered data, pops that port's PIFO head for one cycle, then
// streams the packet's beats from the per-port FWFT buffer until tlast or
// until the beat limit forces termination.
//
// Ports:
//   axis_aclk, axis_reset        clock, async active-high reset
//   s_axis_pifo_empty[p]         PIFO calendar p empty
//   s_axis_buffer_empty[p]       packet buffer p empty (FWFT head)
//   s_axis_buffer_tlast[p]       tlast of buffer p head beat
//   s_axis_out_tready[p]         egress port p ready
//   m_axis_ctl_pifo_out_en       one-hot PIFO pop pulse (POP state)
//   m_axis_ctl_buffer_rd_en      one-hot buffer read, one beat per cycle
//   m_axis_valid                 beat transferred this cycle
//   m_axis_tlast                 beat ends the packet (natural or forced)
//   m_axis_port_sel              granted port, stable POP..last beat
//   m_axis_err                   pulse the cycle after a forced termination
module dequeue_agent_v0_1 #(
    parameter int NUM_PORTS     = 5,
    parameter int PORT_W        = 3,
    parameter int MAX_PKT_BEATS = 64
) (
    input  logic                 axis_aclk,
    input  logic                 axis_reset,
    input  logic [NUM_PORTS-1:0] s_axis_pifo_empty,
    input  logic [NUM_PORTS-1:0] s_axis_buffer_empty,
    input  logic [NUM_PORTS-1:0] s_axis_buffer_tlast,
    input  logic [NUM_PORTS-1:0] s_axis_out_tready,
    output logic [NUM_PORTS-1:0] m_axis_ctl_pifo_out_en,
    output logic [NUM_PORTS-1:0] m_axis_ctl_buffer_rd_en,
    output logic                 m_axis_valid,
    output logic                 m_axis_tlast,
    output logic [PORT_W-1:0]    m_axis_port_sel,
    output logic                 m_axis_err
);

    localparam int CNT_W = $clog2(MAX_PKT_BEATS);

    typedef enum logic [1:0] {IDLE, POP, STREAM} state_t;

    state_t              state;
    logic [PORT_W-1:0]   port_sel_q;
    logic [PORT_W-1:0]   last_grant;
    logic [CNT_W-1:0]    beat_cnt;
    logic                err_q;

    logic [NUM_PORTS-1:0] eligible;
    logic                 grant_found;
    logic [PORT_W-1:0]    grant_idx;
    logic                 beat;
    logic                 cnt_last;
    logic                 tlast;
    logic                 forced;

    assign eligible = ~s_axis_pifo_empty & ~s_axis_buffer_empty;

    // Round-robin search starting just after last_grant. Walking the offsets
    // downward lets the smallest eligible offset overwrite the others, so no
    // loop break is needed.
    always_comb begin
        logic [PORT_W-1:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = PORT_W'((int'(last_grant) + i) % NUM_PORTS);
            if (eligible[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // FWFT stream: a beat moves whenever the granted buffer has data and
    // its egress is ready; the decision is combinational in STREAM.
    assign beat     = (state == STREAM) && !s_axis_buffer_empty[port_sel_q]
                      && s_axis_out_tready[port_sel_q];
    assign cnt_last = (beat_cnt == CNT_W'(MAX_PKT_BEATS - 1));
    assign tlast    = beat && (s_axis_buffer_tlast[port_sel_q] || cnt_last);
    assign forced   = tlast && !s_axis_buffer_tlast[port_sel_q];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign m_axis_ctl_pifo_out_en[p]  = (state == POP) && (port_sel_q == PORT_W'(p));
        assign m_axis_ctl_buffer_rd_en[p] = beat && (port_sel_q == PORT_W'(p));
    end

    assign m_axis_valid    = beat;
    assign m_axis_tlast    = tlast;
    assign m_axis_port_sel = port_sel_q;
    assign m_axis_err      = err_q;

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state      <= IDLE;
            last_grant <= PORT_W'(NUM_PORTS - 1);
            port_sel_q <= '0;
            beat_cnt   <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_found) begin
                        port_sel_q <= grant_idx;
                        last_grant <= grant_idx;
                        beat_cnt   <= '0;
                        state      <= POP;
                    end
                end
                POP: state <= STREAM;
                STREAM: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (tlast) begin
                            // Forced cut leaves the rest of the packet in the buffer.
                            err_q <= forced;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dequeue_agent_v0_1.md
Name: dequeue_agent_v0_1

Overview:
Egress-side counterpart of enqueue_agent_v0_1. It picks a port round-robin among those holding a scheduled packet. It pops that port's PIFO calendar head, then streams the packet's beats out of the per-port packet buffer to the egress port, one packet at a time. It drives the PIFO pop and buffer read-enable controls that mirror the enqueue agent's insert/write controls.

Parameters:
NUM_PORTS, 5, number of egress ports, PIFO calendars and packet buffers (2..8).
PORT_W, 3, width of the port index output (must satisfy 2^PORT_W >= NUM_PORTS).
MAX_PKT_BEATS, 64, beat limit per packet before forced termination (power of 2, >= 2).

Ports:
axis_aclk  in  1  clock; all logic rising-edge.
axis_reset  in  1  asynchronous, active-high reset.
s_axis_pifo_empty  in  NUM_PORTS  bit p=1: PIFO calendar p holds no entry.
s_axis_buffer_empty  in  NUM_PORTS  bit p=1: packet buffer p is empty (first-word-fall-through head).
s_axis_buffer_tlast  in  NUM_PORTS  tlast of the head beat of buffer p; valid only when buffer_empty[p]=0.
s_axis_out_tready  in  NUM_PORTS  egress port p can accept a beat.
m_axis_ctl_pifo_out_en  out  NUM_PORTS  one-hot PIFO pop pulse.
m_axis_ctl_buffer_rd_en  out  NUM_PORTS  one-hot buffer read enable; one beat consumed per asserted cycle.
m_axis_valid  out  1  beat transferred this cycle; equals OR of buffer_rd_en.
m_axis_tlast  out  1  current beat ends the packet (natural or forced).
m_axis_port_sel  out  PORT_W  index of the granted port; held stable from POP through the last beat.
m_axis_err  out  1  one-cycle pulse, cycle after a forced termination.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; last_grant = NUM_PORTS-1, so the first search starts at port 0.
  - Beat counter 0; port_sel 0.
  - All outputs 0.
- FSM states IDLE, POP, STREAM.
- IDLE:
  - Port p is eligible when pifo_empty[p]=0 and buffer_empty[p]=0.
  - Search runs from (last_grant+1) mod NUM_PORTS upward, wrapping; the first eligible port wins.
  - On a win: register grant into port_sel and last_grant, clear beat counter, go to POP at the next edge.
  - No eligible port: stay in IDLE; all outputs 0.
- POP (exactly 1 cycle):
  - pifo_out_en[port_sel]=1, all other bits 0.
  - No buffer read this cycle.
  - Go to STREAM unconditionally.
- STREAM:
  - Outputs are combinational (FWFT): buffer_rd_en[port_sel] = !buffer_empty[port_sel] && out_tready[port_sel]; other bits 0.
  - m_axis_valid equals that term.
  - On a transferred beat: beat counter += 1.
  - m_axis_tlast = valid && (buffer_tlast[port_sel] || beat_cnt == MAX_PKT_BEATS-1).
  - Beat with tlast: go to IDLE at the next edge.
  - Forced termination (tlast caused only by the counter): m_axis_err=1 for the following cycle; remaining beats stay in the buffer.
- Backpressure or underflow in STREAM: no beat, counter holds, state holds indefinitely. There is no timeout on stalls.
- Minimum inter-packet gap: 2 cycles (IDLE + POP) between the last beat of one packet and the first beat of the next.
- Eligibility changes during POP/STREAM are ignored; only one port is served at a time.
- Reset mid-packet: return to IDLE at once. No repeated pop; the partially read packet is abandoned.
- pifo_out_en is asserted at most once per packet, never in the same cycle as a buffer read.

Test Plan:
- Reset with all inputs 0 except pifo_empty=buffer_empty=5'b11111 -> all outputs 0, FSM stays IDLE for 20 cycles; assert axis_reset mid-run -> outputs 0 in the same cycle.
- Port 2 eligible, 3-beat packet (tlast on beat 3), tready all 1 -> cycle 1 pifo_out_en=5'b00100, port_sel=2; cycles 2-4 buffer_rd_en=5'b00100, valid=1; tlast=1 only in cycle 4; IDLE in cycle 5.
- Ports 0 and 3 continuously eligible, 1-beat packets -> grant order 0,3,0,3; new pop every 3 cycles; port_sel alternates 0/3.
- Port 1 packet of 4 beats, out_tready[1]=0 during beats 2-3 for 2 cycles -> rd_en/valid 0 those cycles, counter holds, 4 beats total, tlast on beat 4 only.
- buffer_empty[4] rises for 3 cycles mid-packet -> stall with no rd_en, then resume; no pop of another port during the stall.
- MAX_PKT_BEATS=4, port 0 with no tlast in the buffer -> 4 beats, tlast=1 on beat 4, err=1 the next cycle only, IDLE, then port 0 re-granted if still eligible.
